// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
    typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_JALR, SEL_TRAP} sel_t;
    localparam logic [1:0]  ALIGN_MASK   = 2'b11;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: priority next-PC mux with branch adder and target alignment check.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic        trap,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc,
    output sel_t        sel,
    output logic        misalign
);
    logic [31:0] target;
    always_comb begin
        sel      = trap ? SEL_TRAP : jalr_valid ? SEL_JALR : branch_taken ? SEL_BR : SEL_SEQ;
        target   = (sel == SEL_JALR) ? (jalr_target & ~32'd1) : pc + branch_offset;
        misalign = (sel == SEL_JALR || sel == SEL_BR) && |(target[1:0] & ALIGN_MASK);
        next_pc  = (sel == SEL_TRAP || misalign) ? TRAP_VEC :
                   (sel == SEL_SEQ) ? pc + 32'd4 : target;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs the imem req/ack handshake and sequences fetch/execute.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        trap,
    input  logic        halt,
    output logic        misalign_fault,
    output logic [31:0] instret
);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d, next_pc;
    logic        req_q, req_d, misalign_q, misalign_d, misalign;
    sel_t        sel;

    fetch_next_pc #(.TRAP_VEC(TRAP_VEC)) u_next_pc (
        .pc            (pc_q),
        .trap          (trap),
        .jalr_valid    (jalr_valid),
        .jalr_target   (jalr_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (next_pc),
        .sel           (sel),
        .misalign      (misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE:  state_d = run ? FETCH : IDLE;
            FETCH: begin
                instr_d = imem_ack ? imem_rdata : instr_q;
                state_d = imem_ack ? EXEC : FETCH;
            end
            EXEC: begin
                pc_d       = next_pc;
                misalign_d = misalign;
                instret_d  = (sel != SEL_TRAP && !misalign) ? instret_q + 32'd1 : instret_q;
                state_d    = (halt && !trap) ? HALTED : run ? FETCH : IDLE;
            end
            default: state_d = HALTED;
        endcase
        // Request is registered: it rises with entry into FETCH and drops with the acking edge.
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instret_q  <= '0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            req_q      <= req_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign pc_out         = pc_q;
    assign pc_plus_4      = pc_q + 32'd4;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == EXEC);
    assign misalign_fault = misalign_q;
    assign instret        = instret_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with an imem responder and a scoreboard checking each EXEC.
module tb_fetch_sequencer;
    logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
    logic        imem_req, imem_ack = 1'b0, instr_valid, misalign_fault;
    logic [31:0] imem_addr, imem_rdata = '0, instr, pc_out, pc_plus_4, instret;
    logic        branch_taken = 1'b0, jalr_valid = 1'b0, trap = 1'b0, halt = 1'b0;
    logic [31:0] branch_offset = '0, jalr_target = '0;

    int n_chk = 0, n_fail = 0, delay = 0, cnt = 0, cyc = 0, last_cyc = 0;
    logic stray = 1'b0;
    logic [63:0] exp_q[$];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .pc_out(pc_out), .pc_plus_4(pc_plus_4), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jalr_valid(jalr_valid), .jalr_target(jalr_target),
        .trap(trap), .halt(halt), .misalign_fault(misalign_fault), .instret(instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {8'h13, a[23:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after `delay` wait cycles, otherwise drives stray acks with junk data.
    initial forever begin
        @(negedge clk);
        if (imem_req && cnt >= delay) begin
            imem_ack = 1'b1; imem_rdata = tag(imem_addr); cnt = 0;
        end else begin
            imem_ack = stray; imem_rdata = 32'hDEAD_BEEF; cnt = imem_req ? cnt + 1 : 0;
        end
    end

    // Monitor: every EXEC cycle is matched against the next expected {pc, instr}.
    initial forever begin
        @(negedge clk);
        if (!reset && instr_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_exec: pc %h with empty scoreboard", pc_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("exec_pc", pc_out, e[63:32]);
                check("exec_instr", instr, e[31:0]);
                check("exec_pc_plus_4", pc_plus_4, e[63:32] + 32'd4);
            end
        end
    end

    task automatic exec_step(input logic [31:0] pc, input logic br, input logic [31:0] off,
                             input logic jv, input logic [31:0] jt, input logic tr, input logic hl);
        int n;
        exp_q.push_back({pc, tag(pc)});
        n = 0;
        do begin @(negedge clk); n++; end while (!instr_valid && n < 50);
        if (!instr_valid) begin
            n_chk++; n_fail++;
            $display("FAIL exec_timeout: no EXEC for pc %h", pc);
            void'(exp_q.pop_back());
        end
        last_cyc = cyc;
        branch_taken = br; branch_offset = off; jalr_valid = jv; jalr_target = jt; trap = tr; halt = hl;
        @(posedge clk); #1;
        branch_taken = 0; branch_offset = 0; jalr_valid = 0; jalr_target = 0; trap = 0; halt = 0;
    endtask

    initial begin
        int prev;
        #1;
        check("rst_pc", pc_out, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_misalign", {31'b0, misalign_fault}, 32'h0);
        check("rst_instret", instret, 32'h0);
        @(posedge clk); #1;
        reset = 0; stray = 1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_stray_req", {31'b0, imem_req}, 32'h0);
            check("idle_stray_instr", instr, 32'h0);
        end
        stray = 0; run = 1;
        exec_step(32'h0, 0, 0, 0, 0, 0, 0);
        prev = last_cyc;
        for (int i = 1; i < 4; i++) begin
            exec_step(32'(4 * i), 0, 0, 0, 0, 0, 0);
            check("throughput_gap", 32'(last_cyc - prev), 32'd2);
            prev = last_cyc;
        end
        check("instret_4", instret, 32'd4);
        exec_step(32'h10, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
        exec_step(32'h08, 1, 32'h6, 0, 0, 0, 0);
        check("misalign_pulse", {31'b0, misalign_fault}, 32'h1);
        check("misalign_instret", instret, 32'd5);
        @(posedge clk); #1;
        check("misalign_pulse_end", {31'b0, misalign_fault}, 32'h0);
        exec_step(32'h100, 0, 0, 1, 32'h40, 1, 0);
        check("trap_instret", instret, 32'd5);
        exec_step(32'h100, 0, 0, 1, 32'h41, 0, 0);
        delay = 3;
        repeat (4) begin
            @(negedge clk);
            check("wait_req", {31'b0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'h40);
            check("wait_valid", {31'b0, instr_valid}, 32'h0);
            check("wait_instr", instr, tag(32'h100));
        end
        delay = 0;
        exec_step(32'h40, 0, 0, 1, 32'h20, 0, 0);
        exec_step(32'h20, 0, 0, 0, 0, 0, 1);
        check("halt_pc", pc_out, 32'h24);
        check("halt_instret", instret, 32'd8);
        repeat (4) begin
            @(posedge clk); #1;
            check("halted_req", {31'b0, imem_req}, 32'h0);
            check("halted_valid", {31'b0, instr_valid}, 32'h0);
        end
        reset = 1; #1;
        check("rerst_pc", pc_out, 32'h0);
        check("rerst_instret", instret, 32'h0);
        @(negedge clk); #1;
        reset = 0; delay = 5;
        repeat (2) @(posedge clk); #1;
        check("midfetch_req", {31'b0, imem_req}, 32'h1);
        reset = 1; run = 0; stray = 1; #1;
        check("async_rst_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk); #1;
        reset = 0;
        repeat (2) begin
            @(posedge clk); #1;
            check("late_ack_req", {31'b0, imem_req}, 32'h0);
            check("late_ack_instr", instr, 32'h0);
            check("late_ack_pc", pc_out, 32'h0);
            check("late_ack_valid", {31'b0, instr_valid}, 32'h0);
        end
        stray = 0;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
